reg_write_arbiter: RTL and testbench
====================================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of the shared register and all data ports.
REQ-002 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req  input  3  write request, bit i from requester i.
REQ-005 SHALL have port data0, data1, data2  input  WIDTH each  write data of requesters 0..2.
REQ-006 SHALL have port grant  output  3  one-hot grant, all-zero when no grant is active.
REQ-007 SHALL have port ack  output  3  one-cycle completion pulse to the winning requester.
REQ-008 SHALL have port reg_en  output  1  write enable to the shared register's enable pin.
REQ-009 SHALL have port reg_data  output  WIDTH  data to the shared register's data pins.
REQ-010 SHALL have port busy  output  1  high whenever the FSM is not IDLE.
REQ-011 SHALL have port write_count  output  8  count of completed writes.

Function
REQ-012 SHALL implement the FSM states IDLE, GRANT and WRITE.
REQ-013 In IDLE with req != 0 at a clock edge, the block SHALL select a winner round-robin from pointer ptr and enter GRANT.
REQ-014 Round-robin SHALL search ptr, ptr+1, ptr+2 (mod 3) and pick the first requester with req set.
REQ-015 In GRANT, grant SHALL be one-hot on the winner and reg_data SHALL be loaded with that winner's data at the GRANT-exit edge.
REQ-016 On the GRANT edge, if req[winner]=1 the FSM SHALL enter WRITE; otherwise it SHALL return to IDLE (abort) with no write, no ack, ptr unchanged, write_count unchanged.
REQ-017 In WRITE, the block SHALL hold reg_en=1, grant one-hot on the winner and ack[winner]=1 for exactly one cycle, then return to IDLE.
REQ-018 On the WRITE-exit edge, ptr SHALL become (winner+1) mod 3 and write_count SHALL increment by 1, wrapping 255->0.
REQ-019 Latency SHALL be: req sampled at edge N, grant high in cycle N+1, reg_en/ack high in cycle N+2, IDLE in cycle N+3.
REQ-020 A new request SHALL NOT be sampled until IDLE; back-to-back writes SHALL therefore occur at most once every 3 cycles.
REQ-021 Requester data changes after the GRANT-exit edge SHALL NOT affect reg_data for the current write.
REQ-022 reg_data SHALL hold its last written value outside WRITE; reg_en SHALL be 0 in IDLE and GRANT.
REQ-023 grant and ack SHALL never have more than one bit set; ack SHALL only be set where grant is set.
REQ-024 All outputs SHALL be registered, with no combinational path from req or data inputs to any output.

Reset
REQ-025 Asserting reset SHALL immediately force state=IDLE, ptr=0, grant=0, ack=0, reg_en=0, reg_data=0, busy=0 and write_count=0, independent of clock.
REQ-026 Reset asserted during GRANT or WRITE SHALL abandon the transaction with no ack and no count increment; reg_en SHALL drop within the reset assertion.
REQ-027 After reset deasserts, the first clock edge with req != 0 SHALL start arbitration with requester 0 highest priority.

Verification
REQ-028 Single request: req=3'b010 with data1=8'hA5 held -> grant=3'b010 in cycle N+1, then reg_en=1, reg_data=8'hA5, ack=3'b010 in N+2, write_count=1.
REQ-029 Round-robin: req=3'b111 held continuously after reset -> writes occur in requester order 0,1,2,0 at 3-cycle spacing, and ack matches each.
REQ-030 Abort: req=3'b001 raised for one cycle only -> grant=3'b001 for one cycle, no reg_en, no ack, write_count unchanged, and next winner is still 0.
REQ-031 Data capture: data2 changes 8'h11->8'h22 during WRITE cycle after grant to 2 -> reg_data=8'h11 is written.
REQ-032 Reset mid-op: reset pulses during GRANT -> all outputs 0 immediately, no ack; after release with req=3'b100 -> grant=3'b100.
REQ-033 Counter wrap: 256 completed writes from reset -> write_count returns to 8'h00 with no other effect.

Source files
------------

// File: rtl/reg_write_arbiter_if.sv
// Bundle of request, data and shared-register signals between three writers and the arbiter.
// The master side is the requesters. The slave side is the arbiter driving the shared register.
interface reg_write_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [2:0]       req;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic [2:0]       grant;
    logic [2:0]       ack;
    logic             reg_en;
    logic [WIDTH-1:0] reg_data;
    logic             busy;
    logic [7:0]       write_count;

    modport master (
        output req, data0, data1, data2,
        input  grant, ack, reg_en, reg_data, busy, write_count
    );

    modport slave (
        input  req, data0, data1, data2,
        output grant, ack, reg_en, reg_data, busy, write_count
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that gives three requesters access to one shared register.
// Each write runs IDLE -> GRANT -> WRITE. Every output comes straight from a flop.
module reg_write_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    reg_write_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GRANT, WRITE} state_t;

    state_t           state_reg, state_next;
    logic [1:0]       ptr_reg, ptr_next;
    logic [1:0]       winner_reg, winner_next;
    logic [2:0]       grant_reg, grant_next;
    logic [2:0]       ack_reg, ack_next;
    logic             reg_en_reg, reg_en_next;
    logic [WIDTH-1:0] reg_data_reg, reg_data_next;
    logic             busy_reg, busy_next;
    logic [7:0]       count_reg, count_next;

    logic             rr_found;
    logic [1:0]       rr_winner;
    logic [2:0]       rr_idx;
    logic [WIDTH-1:0] winner_data;

    function automatic logic [2:0] onehot(input logic [1:0] idx);
        return 3'b001 << idx;
    endfunction

    // Search order is ptr, ptr+1, ptr+2 (mod 3). The first active request wins.
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = ptr_reg;
        rr_idx    = 3'd0;
        for (int k = 0; k < 3; k++) begin
            rr_idx = {1'b0, ptr_reg} + 3'(k);
            if (rr_idx >= 3'd3)
                rr_idx = rr_idx - 3'd3;
            if (!rr_found && bus.req[rr_idx[1:0]]) begin
                rr_found  = 1'b1;
                rr_winner = rr_idx[1:0];
            end
        end
    end

    always_comb begin
        case (winner_reg)
            2'd0:    winner_data = bus.data0;
            2'd1:    winner_data = bus.data1;
            default: winner_data = bus.data2;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            ptr_reg      <= 2'd0;
            winner_reg   <= 2'd0;
            grant_reg    <= 3'b000;
            ack_reg      <= 3'b000;
            reg_en_reg   <= 1'b0;
            reg_data_reg <= '0;
            busy_reg     <= 1'b0;
            count_reg    <= 8'd0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            winner_reg   <= winner_next;
            grant_reg    <= grant_next;
            ack_reg      <= ack_next;
            reg_en_reg   <= reg_en_next;
            reg_data_reg <= reg_data_next;
            busy_reg     <= busy_next;
            count_reg    <= count_next;
        end
    end

    // Pulse-type outputs default to zero. Pointer, winner, data and count hold.
    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        winner_next   = winner_reg;
        grant_next    = 3'b000;
        ack_next      = 3'b000;
        reg_en_next   = 1'b0;
        reg_data_next = reg_data_reg;
        busy_next     = 1'b0;
        count_next    = count_reg;
        case (state_reg)
            IDLE: begin
                if (rr_found) begin
                    state_next  = GRANT;
                    winner_next = rr_winner;
                    grant_next  = onehot(rr_winner);
                    busy_next   = 1'b1;
                end
            end
            GRANT: begin
                // A requester that has dropped its request by now aborts the write.
                if (bus.req[winner_reg]) begin
                    state_next    = WRITE;
                    grant_next    = grant_reg;
                    ack_next      = onehot(winner_reg);
                    reg_en_next   = 1'b1;
                    reg_data_next = winner_data;
                    busy_next     = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            WRITE: begin
                state_next = IDLE;
                ptr_next   = (winner_reg == 2'd2) ? 2'd0 : winner_reg + 2'd1;
                count_next = count_reg + 8'd1;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.grant       = grant_reg;
    assign bus.ack         = ack_reg;
    assign bus.reg_en      = reg_en_reg;
    assign bus.reg_data    = reg_data_reg;
    assign bus.busy        = busy_reg;
    assign bus.write_count = count_reg;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter. Expected values are hand-computed.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_reg_write_arbiter;
    localparam int WIDTH = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    reg_write_arbiter_if #(.WIDTH(WIDTH)) bus ();

    reg_write_arbiter #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] oh(input int who);
        logic [2:0] one;
        one = 3'b001;
        return one << who;
    endfunction

    // The request must already be driven on the preceding falling edge.
    // Covers the grant cycle, the write cycle and the return to idle.
    task automatic do_write(input int who, input logic [7:0] dat, input logic [7:0] cnt,
                            input bit drop, input string tag);
        @(negedge clock);
        check_val({tag, "_grant"},   32'(bus.grant),  32'(oh(who)));
        check_val({tag, "_busy"},    32'(bus.busy),   32'd1);
        check_val({tag, "_en_g"},    32'(bus.reg_en), 32'd0);
        check_val({tag, "_ack_g"},   32'(bus.ack),    32'd0);
        @(negedge clock);
        check_val({tag, "_en"},      32'(bus.reg_en),   32'd1);
        check_val({tag, "_ack"},     32'(bus.ack),      32'(oh(who)));
        check_val({tag, "_grant_w"}, 32'(bus.grant),    32'(oh(who)));
        check_val({tag, "_data"},    32'(bus.reg_data), 32'(dat));
        if (drop)
            bus.req = 3'b000;
        @(negedge clock);
        check_val({tag, "_idle"},    32'(bus.busy),        32'd0);
        check_val({tag, "_en_i"},    32'(bus.reg_en),      32'd0);
        check_val({tag, "_ack_i"},   32'(bus.ack),         32'd0);
        check_val({tag, "_count"},   32'(bus.write_count), 32'(cnt));
        $display("write %s: winner=%0d data=%h count=%0d", tag, who, bus.reg_data, bus.write_count);
    endtask

    // Holds reset across one rising edge and releases it on a falling edge.
    task automatic pulse_reset();
        @(negedge clock);
        reset   = 1'b1;
        bus.req = 3'b000;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        bus.req   = 3'b000;
        bus.data0 = 8'h10;
        bus.data1 = 8'h20;
        bus.data2 = 8'h30;
        #2 reset = 1'b1;
        #1;
        check_val("rst_grant", 32'(bus.grant),       32'd0);
        check_val("rst_ack",   32'(bus.ack),         32'd0);
        check_val("rst_en",    32'(bus.reg_en),      32'd0);
        check_val("rst_data",  32'(bus.reg_data),    32'd0);
        check_val("rst_busy",  32'(bus.busy),        32'd0);
        check_val("rst_count", 32'(bus.write_count), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Single request from requester 1
        bus.req   = 3'b010;
        bus.data1 = 8'hA5;
        do_write(1, 8'hA5, 8'd1, 1'b1, "single");
        bus.data1 = 8'h20;

        // Round-robin with all requests held after reset
        pulse_reset();
        bus.req = 3'b111;
        do_write(0, 8'h10, 8'd1, 1'b0, "rr0");
        do_write(1, 8'h20, 8'd2, 1'b0, "rr1");
        do_write(2, 8'h30, 8'd3, 1'b0, "rr2");
        do_write(0, 8'h10, 8'd4, 1'b1, "rr3");

        // Abort: request withdrawn before the grant is used
        pulse_reset();
        bus.req = 3'b001;
        @(negedge clock);
        check_val("abort_grant", 32'(bus.grant), 32'b001);
        bus.req = 3'b000;
        @(negedge clock);
        check_val("abort_grant_off", 32'(bus.grant),       32'd0);
        check_val("abort_en",        32'(bus.reg_en),      32'd0);
        check_val("abort_ack",       32'(bus.ack),         32'd0);
        check_val("abort_busy",      32'(bus.busy),        32'd0);
        check_val("abort_count",     32'(bus.write_count), 32'd0);
        $display("abort: grant withdrawn, count=%0d", bus.write_count);
        bus.req = 3'b111;
        do_write(0, 8'h10, 8'd1, 1'b1, "after_abort");

        // Data capture: data2 changes during the write cycle
        bus.req   = 3'b100;
        bus.data2 = 8'h11;
        @(negedge clock);
        check_val("cap_grant", 32'(bus.grant), 32'b100);
        @(negedge clock);
        check_val("cap_en",   32'(bus.reg_en),   32'd1);
        check_val("cap_data", 32'(bus.reg_data), 32'h11);
        bus.data2 = 8'h22;
        bus.req   = 3'b000;
        @(negedge clock);
        check_val("cap_hold",  32'(bus.reg_data),    32'h11);
        check_val("cap_count", 32'(bus.write_count), 32'd2);
        @(negedge clock);
        check_val("cap_hold2", 32'(bus.reg_data), 32'h11);
        $display("capture: reg_data=%h", bus.reg_data);

        // Reset arriving while a grant is active
        bus.req = 3'b001;
        @(negedge clock);
        check_val("mid_grant", 32'(bus.grant), 32'b001);
        #1 reset = 1'b1;
        #1;
        check_val("mid_rst_grant", 32'(bus.grant),       32'd0);
        check_val("mid_rst_busy",  32'(bus.busy),        32'd0);
        check_val("mid_rst_data",  32'(bus.reg_data),    32'd0);
        check_val("mid_rst_count", 32'(bus.write_count), 32'd0);
        check_val("mid_rst_en",    32'(bus.reg_en),      32'd0);
        bus.req = 3'b100;
        @(negedge clock);
        check_val("mid_rst_ack", 32'(bus.ack), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check_val("mid_after_grant", 32'(bus.grant), 32'b100);
        @(negedge clock);
        check_val("mid_after_ack", 32'(bus.ack), 32'b100);
        bus.req = 3'b000;
        @(negedge clock);
        check_val("mid_after_count", 32'(bus.write_count), 32'd1);
        $display("reset mid-op: recovered, count=%0d", bus.write_count);

        // Counter wrap after 256 writes
        pulse_reset();
        bus.req = 3'b111;
        repeat (3 * 255) @(negedge clock);
        check_val("wrap_255", 32'(bus.write_count), 32'd255);
        repeat (3) @(negedge clock);
        check_val("wrap_0",    32'(bus.write_count), 32'd0);
        check_val("wrap_busy", 32'(bus.busy),        32'd0);
        check_val("wrap_en",   32'(bus.reg_en),      32'd0);
        @(negedge clock);
        check_val("wrap_next_grant", 32'(bus.grant), 32'b010);
        bus.req = 3'b000;
        $display("wrap: count=%0d after 256 writes", bus.write_count);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
